// File: rtl/mem_access_port.sv
// mem_access_port: MAR/MDR memory-access unit with ack handshake and timeout
module mem_access_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read_req,
  input  logic              write_req,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mar_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (state_q == IDLE) begin
      mar_d = mar_in ? bus_in[ADDR_W-1:0] : mar_q;
      mdr_d = mdr_in ? bus_in : mdr_q;
      if (read_req || write_req) begin
        state_d = read_req ? RD : WR;
        cnt_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        rd_d    = read_req;
        wr_d    = !read_req;
      end
    end else if (mem_ack || cnt_q == LAST) begin
      // an ack in the final wait cycle still counts as success
      mdr_d   = (mem_ack && state_q == RD) ? mem_rdata : mdr_q;
      err_d   = !mem_ack;
      state_d = IDLE;
      busy_d  = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      done_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  assign mdr_out   = mdr_q;
  assign mar_out   = mar_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
endmodule
